// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scancode constants, key indices and prefix states
// used by the scancode decoder and its bench.
package ps2_pkg;

    localparam logic [7:0] SC_NONE  = 8'h00;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam int NUM_KEYS = 5;

    typedef enum logic [2:0] {
        KEY_UP    = 3'd0,
        KEY_DOWN  = 3'd1,
        KEY_LEFT  = 3'd2,
        KEY_RIGHT = 3'd3,
        KEY_SPACE = 3'd4
    } key_e;

    typedef enum logic [1:0] {
        PFX_IDLE,
        PFX_EXT,
        PFX_BRK,
        PFX_EXT_BRK
    } prefix_e;

    typedef struct packed {
        logic hit;
        key_e key;
    } key_hit_t;

    // Arrow keys only exist as E0-extended codes; the same bytes alone are keypad keys.
    function automatic key_hit_t ext_lookup(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.key = KEY_UP;
        case (code)
            SC_UP:    r.key = KEY_UP;
            SC_DOWN:  r.key = KEY_DOWN;
            SC_LEFT:  r.key = KEY_LEFT;
            SC_RIGHT: r.key = KEY_RIGHT;
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Show-ahead event FIFO with simultaneous push/pop at any occupancy and a
// sticky overflow flag for pushes dropped while full.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, pop, push_ok;

    assign valid_o = (count_q != '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop     = valid_o & ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push_i & (~full | pop);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (push_i && !push_ok) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/scancode_decoder.sv
// PS/2 set-2 decoder for arrow keys and space: prefix FSM, held key levels
// and a queue of press/release events for a downstream consumer.
//
// state       | meaning
// PFX_IDLE    | no prefix pending
// PFX_EXT     | E0 seen, waiting for extended code or F0
// PFX_BRK     | F0 seen, waiting for released code
// PFX_EXT_BRK | E0 F0 seen, waiting for released extended code
module scancode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SCAN_CODE,
    output logic [4:0] KEY_STATE,
    output logic       EVT_VALID,
    input  logic       EVT_READY,
    output logic [2:0] EVT_KEY,
    output logic       EVT_MAKE,
    output logic       OVERFLOW
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    prefix_e              state_q, state_d;
    logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [NUM_KEYS-1:0]  key_q, key_d;
    logic                 byte_vld, timeout;
    key_hit_t             ext_hit;
    logic                 ev_vld, ev_make, push;
    key_e                 ev_key;
    logic [3:0]           fifo_dout;

    assign byte_vld = (SCAN_CODE != SC_NONE);
    assign ext_hit  = ext_lookup(SCAN_CODE);
    assign timeout  = (state_q != PFX_IDLE) && !byte_vld
                      && (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        ev_vld  = 1'b0;
        ev_key  = KEY_UP;
        ev_make = 1'b0;
        if (byte_vld) begin
            case (state_q)
                PFX_IDLE: begin
                    if (SCAN_CODE == SC_EXT) begin
                        state_d = PFX_EXT;
                    end else if (SCAN_CODE == SC_BRK) begin
                        state_d = PFX_BRK;
                    end else if (SCAN_CODE == SC_SPACE) begin
                        ev_vld  = 1'b1;
                        ev_key  = KEY_SPACE;
                        ev_make = 1'b1;
                    end
                end
                PFX_EXT: begin
                    state_d = PFX_IDLE;
                    if (SCAN_CODE == SC_BRK) begin
                        state_d = PFX_EXT_BRK;
                    end else if (ext_hit.hit) begin
                        ev_vld  = 1'b1;
                        ev_key  = ext_hit.key;
                        ev_make = 1'b1;
                    end
                end
                PFX_BRK: begin
                    state_d = PFX_IDLE;
                    if (SCAN_CODE == SC_SPACE) begin
                        ev_vld = 1'b1;
                        ev_key = KEY_SPACE;
                    end
                end
                PFX_EXT_BRK: begin
                    state_d = PFX_IDLE;
                    if (ext_hit.hit) begin
                        ev_vld = 1'b1;
                        ev_key = ext_hit.key;
                    end
                end
                default: state_d = PFX_IDLE;
            endcase
        end else if (timeout) begin
            state_d = PFX_IDLE;
        end
    end

    // Only level changes become events, which suppresses typematic repeats.
    always_comb begin
        key_d = key_q;
        push  = ev_vld && (key_q[ev_key] != ev_make);
        if (push) begin
            key_d[ev_key] = ev_make;
        end
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
        if (byte_vld || timeout || state_q == PFX_IDLE) begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= PFX_IDLE;
            idle_cnt_q <= '0;
            key_q      <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            key_q      <= key_d;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_event_fifo (
        .clk_i      (CLK),
        .rst_i      (RST),
        .push_i     (push),
        .data_i     ({ev_key, ev_make}),
        .ready_i    (EVT_READY),
        .valid_o    (EVT_VALID),
        .data_o     (fifo_dout),
        .overflow_o (OVERFLOW)
    );

    assign KEY_STATE = key_q;
    assign EVT_KEY   = fifo_dout[3:1];
    assign EVT_MAKE  = fifo_dout[0];

endmodule
